integer_station_pool: RTL and testbench

Multi-entry integer reservation station. Holds ENTRY_COUNT pending integer operations, captures missing operands from BUS_COUNT result-broadcast buses, issues the oldest ready entry through the ALU into a one-deep output register, and presents the result with a valid/ready handshake to the bus arbiter. Sits between the dispatch stage and the common result buses, in place of single-entry integer stations.

---
 rtl/integer_station_pkg.sv | 15 +
 rtl/integer_alu.sv | 31 +++
 rtl/integer_station_pool.sv | 194 +++++++++++++++++++
 tb/tb_integer_station_pool.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/integer_station_pkg.sv
// Operation encodings shared by the integer reservation station and its ALU.
package integer_station_pkg;
  localparam int OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_SLL  = 4'd5;
  localparam logic [OP_WIDTH-1:0] OP_SRL  = 4'd6;
  localparam logic [OP_WIDTH-1:0] OP_SRA  = 4'd7;
  localparam logic [OP_WIDTH-1:0] OP_SLTU = 4'd8;
  localparam logic [OP_WIDTH-1:0] OP_SLT  = 4'd9;
endpackage

// File: rtl/integer_alu.sv
// Combinational integer ALU; unknown operation codes produce zero.
module integer_alu
  import integer_station_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [OP_WIDTH-1:0] operation_i,
  input  logic [SIZE-1:0]     a_i,
  input  logic [SIZE-1:0]     b_i,
  output logic [SIZE-1:0]     result_o
);
  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (operation_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $signed(a_i) >>> shamt;
      OP_SLTU: result_o = {{(SIZE-1){1'b0}}, (a_i < b_i)};
      OP_SLT:  result_o = {{(SIZE-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: result_o = '0;
    endcase
  end
endmodule

// File: rtl/integer_station_pool.sv
// Multi-entry integer reservation station: snoops result buses for missing
// operands and issues the oldest ready entry into a one-deep output register.
module integer_station_pool
  import integer_station_pkg::*;
#(
  parameter int SIZE               = 32,
  parameter int STATION_INDEX_SIZE = 4,
  parameter int BUS_COUNT          = 2,
  parameter int ENTRY_COUNT        = 4,
  parameter int ENTRY_INDEX_SIZE   = 2
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    flush,
  input  logic                                    dispatch_valid,
  output logic                                    dispatch_ready,
  input  logic [OP_WIDTH-1:0]                     dispatch_operation,
  input  logic [STATION_INDEX_SIZE-1:0]           dispatch_tag,
  input  logic                                    preload_a_value,
  input  logic                                    preload_b_value,
  input  logic [STATION_INDEX_SIZE-1:0]           a_source,
  input  logic [STATION_INDEX_SIZE-1:0]           b_source,
  input  logic [SIZE-1:0]                         preloaded_a_value,
  input  logic [SIZE-1:0]                         preloaded_b_value,
  output logic                                    result_valid,
  input  logic                                    result_ready,
  output logic [SIZE-1:0]                         result_value,
  output logic [STATION_INDEX_SIZE-1:0]           result_tag,
  input  logic [BUS_COUNT-1:0]                    bus_asserted,
  input  logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source,
  input  logic [SIZE*BUS_COUNT-1:0]               bus_value
);
  localparam int TW = STATION_INDEX_SIZE;

  typedef struct packed {
    logic                occupied;
    logic [OP_WIDTH-1:0] op;
    logic [TW-1:0]       tag;
    logic                a_loaded;
    logic [TW-1:0]       a_source;
    logic [SIZE-1:0]     a_value;
    logic                b_loaded;
    logic [TW-1:0]       b_source;
    logic [SIZE-1:0]     b_value;
  } entry_t;

  entry_t                 entry_q [ENTRY_COUNT];
  entry_t                 entry_d [ENTRY_COUNT];
  // older_q[i][j] set means entry i was allocated before entry j.
  logic [ENTRY_COUNT-1:0] older_q [ENTRY_COUNT];
  logic [ENTRY_COUNT-1:0] older_d [ENTRY_COUNT];
  logic                   result_valid_q, result_valid_d;
  logic [SIZE-1:0]        result_value_q, result_value_d;
  logic [TW-1:0]          result_tag_q, result_tag_d;

  logic [ENTRY_COUNT-1:0]      ready, oldest;
  logic [ENTRY_INDEX_SIZE-1:0] alloc_idx, issue_idx;
  logic                        alloc_found, issue_any, can_issue;
  logic [SIZE:0]               snoop_a, snoop_b;
  entry_t                      new_entry;
  logic [SIZE-1:0]             alu_result;

  // Returns {hit, value}; iterating downward lets the lowest bus index win.
  function automatic logic [SIZE:0] snoop(input logic [TW-1:0] src);
    logic [SIZE:0] hit;
    hit = '0;
    for (int b = BUS_COUNT - 1; b >= 0; b--) begin
      if (bus_asserted[b] && bus_source[b*TW +: TW] == src)
        hit = {1'b1, bus_value[b*SIZE +: SIZE]};
    end
    return hit;
  endfunction

  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    issue_idx   = '0;
    issue_any   = 1'b0;
    for (int i = 0; i < ENTRY_COUNT; i++)
      ready[i] = entry_q[i].occupied && entry_q[i].a_loaded && entry_q[i].b_loaded;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      oldest[i] = ready[i];
      for (int j = 0; j < ENTRY_COUNT; j++)
        if (ready[j] && older_q[j][i]) oldest[i] = 1'b0;
    end
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if (!entry_q[i].occupied && !alloc_found) begin
        alloc_idx   = ENTRY_INDEX_SIZE'(i);
        alloc_found = 1'b1;
      end
      if (oldest[i] && !issue_any) begin
        issue_idx = ENTRY_INDEX_SIZE'(i);
        issue_any = 1'b1;
      end
    end
  end

  assign dispatch_ready = alloc_found;
  assign can_issue      = !result_valid_q || result_ready;

  integer_alu #(.SIZE(SIZE)) u_alu (
    .operation_i (entry_q[issue_idx].op),
    .a_i         (entry_q[issue_idx].a_value),
    .b_i         (entry_q[issue_idx].b_value),
    .result_o    (alu_result)
  );

  // Handshakes: dispatch accepted on dispatch_valid && dispatch_ready; result
  // value/tag held stable while result_valid && !result_ready.
  always_comb begin
    entry_d        = entry_q;
    older_d        = older_q;
    result_valid_d = result_valid_q;
    result_value_d = result_value_q;
    result_tag_d   = result_tag_q;
    snoop_a        = '0;
    snoop_b        = '0;
    new_entry      = '0;

    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if (entry_q[i].occupied) begin
        snoop_a = snoop(entry_q[i].a_source);
        snoop_b = snoop(entry_q[i].b_source);
        if (!entry_q[i].a_loaded && snoop_a[SIZE]) begin
          entry_d[i].a_loaded = 1'b1;
          entry_d[i].a_value  = snoop_a[SIZE-1:0];
        end
        if (!entry_q[i].b_loaded && snoop_b[SIZE]) begin
          entry_d[i].b_loaded = 1'b1;
          entry_d[i].b_value  = snoop_b[SIZE-1:0];
        end
      end
    end

    if (can_issue) begin
      result_valid_d = issue_any;
      if (issue_any) begin
        entry_d[issue_idx].occupied = 1'b0;
        result_value_d = alu_result;
        result_tag_d   = entry_q[issue_idx].tag;
      end
    end

    if (dispatch_valid && dispatch_ready) begin
      snoop_a            = snoop(a_source);
      snoop_b            = snoop(b_source);
      new_entry.occupied = 1'b1;
      new_entry.op       = dispatch_operation;
      new_entry.tag      = dispatch_tag;
      new_entry.a_source = a_source;
      new_entry.b_source = b_source;
      new_entry.a_loaded = preload_a_value || snoop_a[SIZE];
      new_entry.b_loaded = preload_b_value || snoop_b[SIZE];
      new_entry.a_value  = preload_a_value ? preloaded_a_value : snoop_a[SIZE-1:0];
      new_entry.b_value  = preload_b_value ? preloaded_b_value : snoop_b[SIZE-1:0];
      entry_d[alloc_idx] = new_entry;
      for (int j = 0; j < ENTRY_COUNT; j++)
        older_d[j][alloc_idx] = entry_q[j].occupied;
      older_d[alloc_idx] = '0;
    end

    if (flush) begin
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        entry_d[i].occupied = 1'b0;
        older_d[i]          = '0;
      end
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        entry_q[i] <= '0;
        older_q[i] <= '0;
      end
      result_valid_q <= 1'b0;
      result_value_q <= '0;
      result_tag_q   <= '0;
    end else begin
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        entry_q[i] <= entry_d[i];
        older_q[i] <= older_d[i];
      end
      result_valid_q <= result_valid_d;
      result_value_q <= result_value_d;
      result_tag_q   <= result_tag_d;
    end
  end

  assign result_valid = result_valid_q;
  assign result_value = result_value_q;
  assign result_tag   = result_tag_q;
endmodule

// File: tb/tb_integer_station_pool.sv
// Directed bench for integer_station_pool: hand-computed results, latency,
// age ordering, stall stability and flush behaviour.
module tb_integer_station_pool;
  import integer_station_pkg::*;

  logic        clock, reset, flush;
  logic        dispatch_valid, dispatch_ready;
  logic [3:0]  dispatch_operation, dispatch_tag;
  logic        preload_a_value, preload_b_value;
  logic [3:0]  a_source, b_source;
  logic [31:0] preloaded_a_value, preloaded_b_value;
  logic        result_valid, result_ready;
  logic [31:0] result_value;
  logic [3:0]  result_tag;
  logic [1:0]  bus_asserted;
  logic [7:0]  bus_source;
  logic [63:0] bus_value;

  int vectors     = 0;
  int miscompares = 0;

  integer_station_pool dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .dispatch_valid     (dispatch_valid),
    .dispatch_ready     (dispatch_ready),
    .dispatch_operation (dispatch_operation),
    .dispatch_tag       (dispatch_tag),
    .preload_a_value    (preload_a_value),
    .preload_b_value    (preload_b_value),
    .a_source           (a_source),
    .b_source           (b_source),
    .preloaded_a_value  (preloaded_a_value),
    .preloaded_b_value  (preloaded_b_value),
    .result_valid       (result_valid),
    .result_ready       (result_ready),
    .result_value       (result_value),
    .result_tag         (result_tag),
    .bus_asserted       (bus_asserted),
    .bus_source         (bus_source),
    .bus_value          (bus_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] value, input logic [3:0] rtag);
    check({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
    check({tag, "_value"}, result_value, value);
    check({tag, "_tag"}, {28'd0, result_tag}, {28'd0, rtag});
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [3:0] tag,
                          input logic pa, input logic [31:0] av, input logic [3:0] asrc,
                          input logic pb, input logic [31:0] bv, input logic [3:0] bsrc);
    dispatch_operation = op;
    dispatch_tag       = tag;
    preload_a_value    = pa;
    preloaded_a_value  = av;
    a_source           = asrc;
    preload_b_value    = pb;
    preloaded_b_value  = bv;
    b_source           = bsrc;
    dispatch_valid     = 1'b1;
    tick();
    dispatch_valid     = 1'b0;
    preload_a_value    = 1'b0;
    preload_b_value    = 1'b0;
  endtask

  task automatic drive_bus(input int n, input logic [3:0] src, input logic [31:0] val);
    bus_asserted[n]        = 1'b1;
    bus_source[n*4 +: 4]   = src;
    bus_value[n*32 +: 32]  = val;
  endtask

  task automatic clear_bus();
    bus_asserted = '0;
    bus_source   = '0;
    bus_value    = '0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; result_ready = 1'b0;
    dispatch_operation = '0; dispatch_tag = '0;
    preload_a_value = 1'b0; preload_b_value = 1'b0;
    a_source = '0; b_source = '0; preloaded_a_value = '0; preloaded_b_value = '0;
    clear_bus();
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_value", result_value, 32'd0);
    check("rst_tag", {28'd0, result_tag}, 32'd0);
    check("rst_dready", {31'd0, dispatch_ready}, 32'd1);

    // Preloaded add: two-cycle latency.
    result_ready = 1'b1;
    dispatch(OP_ADD, 4'd5, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    check("add_early", {31'd0, result_valid}, 32'd0);
    tick();
    check_result("add", 32'd12, 4'd5);
    tick();
    check("add_drain", {31'd0, result_valid}, 32'd0);

    // Bus1 capture, then both buses matching (bus0 wins).
    dispatch(OP_SUB, 4'd6, 1'b1, 32'd10, 4'd0, 1'b0, 32'd0, 4'd3);
    tick();
    drive_bus(1, 4'd3, 32'd4);
    tick();
    clear_bus();
    check("sub_wait", {31'd0, result_valid}, 32'd0);
    tick();
    check_result("sub_bus1", 32'd6, 4'd6);
    dispatch(OP_SUB, 4'd7, 1'b1, 32'd10, 4'd0, 1'b0, 32'd0, 4'd3);
    tick();
    drive_bus(0, 4'd3, 32'd4);
    drive_bus(1, 4'd3, 32'd9);
    tick();
    clear_bus();
    tick();
    check_result("sub_prio", 32'd6, 4'd7);

    // Dispatch-cycle bypass.
    drive_bus(0, 4'd2, 32'd3);
    dispatch(OP_SUB, 4'd8, 1'b1, 32'd20, 4'd0, 1'b0, 32'd0, 4'd2);
    clear_bus();
    tick();
    check_result("bypass", 32'd17, 4'd8);
    tick();
    check("bypass_drain", {31'd0, result_valid}, 32'd0);

    // Fill all entries, stall output, release operands youngest first.
    result_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      dispatch(OP_ADD, 4'(k), 1'b1, 32'd100 + 32'(k), 4'd0, 1'b0, 32'd0, 4'(9 + k));
    check("full_dready", {31'd0, dispatch_ready}, 32'd0);
    dispatch(OP_ADD, 4'd15, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    check("full_ignored", {31'd0, dispatch_ready}, 32'd0);
    drive_bus(0, 4'd12, 32'd3);
    tick();
    clear_bus();
    check("full_wait", {31'd0, result_valid}, 32'd0);
    tick();
    check_result("young_first", 32'd106, 4'd3);
    check("freed_dready", {31'd0, dispatch_ready}, 32'd1);
    drive_bus(0, 4'd9, 32'd0);
    drive_bus(1, 4'd10, 32'd1);
    tick();
    clear_bus();
    drive_bus(0, 4'd11, 32'd2);
    tick();
    clear_bus();
    tick();
    check_result("stall_hold", 32'd106, 4'd3);
    result_ready = 1'b1;
    tick();
    check_result("age0", 32'd100, 4'd0);
    tick();
    check_result("age1", 32'd102, 4'd1);
    tick();
    check_result("age2", 32'd104, 4'd2);
    tick();
    check("age_drain", {31'd0, result_valid}, 32'd0);

    // Stalled sra result with a second ready entry waiting.
    result_ready = 1'b0;
    dispatch(OP_SRA, 4'd4, 1'b1, 32'hFFFF_FFFF, 4'd0, 1'b1, 32'd4, 4'd0);
    dispatch(OP_XOR, 4'd9, 1'b1, 32'h0000_00F0, 4'd0, 1'b1, 32'h0000_00FF, 4'd0);
    check_result("sra", 32'hFFFF_FFFF, 4'd4);
    tick();
    check_result("sra_hold1", 32'hFFFF_FFFF, 4'd4);
    tick();
    check_result("sra_hold2", 32'hFFFF_FFFF, 4'd4);
    result_ready = 1'b1;
    tick();
    check_result("xor", 32'h0000_000F, 4'd9);
    tick();
    check("xor_drain", {31'd0, result_valid}, 32'd0);

    // Flush with three entries occupied and a pending result.
    result_ready = 1'b0;
    dispatch(OP_ADD, 4'd1, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
    dispatch(OP_ADD, 4'd2, 1'b1, 32'd0, 4'd0, 1'b0, 32'd0, 4'd13);
    dispatch(OP_OR, 4'd3, 1'b1, 32'd4, 4'd0, 1'b1, 32'd1, 4'd0);
    dispatch(OP_ADD, 4'd4, 1'b1, 32'd0, 4'd0, 1'b0, 32'd0, 4'd14);
    check_result("pre_flush", 32'd3, 4'd1);
    flush = 1'b1;
    result_ready = 1'b1;
    dispatch(OP_ADD, 4'd5, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    flush = 1'b0;
    check("flush_valid", {31'd0, result_valid}, 32'd0);
    check("flush_dready", {31'd0, dispatch_ready}, 32'd1);
    drive_bus(0, 4'd13, 32'd5);
    drive_bus(1, 4'd14, 32'd6);
    tick();
    clear_bus();
    tick();
    check("flush_nostale1", {31'd0, result_valid}, 32'd0);
    tick();
    check("flush_nostale2", {31'd0, result_valid}, 32'd0);

    // Compare and shift operations back-to-back.
    dispatch(OP_SLT, 4'd10, 1'b1, 32'hFFFF_FFFF, 4'd0, 1'b1, 32'd1, 4'd0);
    dispatch(OP_SLTU, 4'd11, 1'b1, 32'hFFFF_FFFF, 4'd0, 1'b1, 32'd1, 4'd0);
    check_result("slt", 32'd1, 4'd10);
    dispatch(OP_SLL, 4'd12, 1'b1, 32'd3, 4'd0, 1'b1, 32'h0000_0024, 4'd0);
    check_result("sltu", 32'd0, 4'd11);
    tick();
    check_result("sll", 32'h0000_0030, 4'd12);
    tick();
    check("final_drain", {31'd0, result_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
